ring_osc_freq_meter: RTL and testbench
======================================

// Module: ring_osc_freq_meter
// PURPOSE
//  Sequencer/measurement controller for the divided ring-oscillator clock. On request it
//  enables the oscillator, waits for it to settle, counts rising edges of its divided output
//  over a fixed window of system-clock cycles, and returns the count via a valid/ready handshake.
//  Used for TDC delay-line calibration and for detecting a stuck oscillator. Everything runs in
//  the system clock domain; osc_in is asynchronous.
// PARAMETERS
//  GATE_CYCLES    1024  length of the count window, in clk cycles (>=4)
//  WARMUP_CYCLES  16    settle time after osc_en rises, before counting starts (>=3)
//  CNT_W          16    width of the edge counter and of result
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-high reset
//  start         in   1      1-cycle request; accepted only in IDLE
//  abort         in   1      return to IDLE from any state; no result is produced
//  osc_in        in   1      divided ring-oscillator output, asynchronous to clk
//  osc_en        out  1      enable to the ring oscillator
//  busy          out  1      high in every state except IDLE
//  result        out  CNT_W  edge count; held stable while result_valid is high
//  result_ovf    out  1      count saturated; qualified by result_valid
//  result_valid  out  1      result available
//  result_ready  in   1      consumer accepts result while result_valid is high
// BEHAVIOUR
//  - Reset: state=IDLE; osc_en, busy, result_valid and result_ovf are 0; result is 0;
//    synchronizer flops are cleared.
//  - Synchronizer: two flops (s1, s2) plus a history flop s3. edge = s2 & ~s3.
//    This adds 2-3 cycles of latency, which is accepted and not compensated.
//  - States:
//    IDLE:   osc_en=0. If start (and no abort): clear counter and ovf, then go to WARMUP.
//    WARMUP: osc_en=1. Timer runs WARMUP_CYCLES cycles, then go to COUNT. Edges are ignored.
//    COUNT:  osc_en=1. Lasts exactly GATE_CYCLES cycles. Each cycle with edge=1 adds 1.
//            At 2^CNT_W-1 the counter holds and sets ovf. After the last cycle: latch result,
//            set result_valid, go to DONE. An edge in the last COUNT cycle is counted.
//    DONE:   osc_en=0. result_valid=1. When result_ready=1: clear result_valid next cycle,
//            go to IDLE. result and result_ovf keep their last value after that.
//  - start is ignored when not in IDLE. It is not queued.
//  - abort has priority over start and over every other transition. It sends the FSM to IDLE
//    on the next cycle and drops osc_en, busy and result_valid. An aborted DONE discards
//    the result.
//  - A start in the same cycle that DONE is left is ignored. IDLE needs one cycle before a
//    new start is accepted.
//  - Reset mid-operation behaves the same as abort and also clears result.
//  - Timer width is clog2(max(GATE_CYCLES, WARMUP_CYCLES)) + 1. Timer is reloaded on every
//    state entry.
// CONFIGURATION
//  RING_OSC_CONT_EN
//    defined:   adds input port `continuous` (1 bit). In DONE, on handshake with
//               continuous=1, go to WARMUP instead of IDLE (counter and ovf cleared).
//               osc_en stays high through DONE in this case, so no gap in enable.
//               With continuous=0 the behaviour is as above. abort still wins.
//    undefined: the port does not exist. Behaviour is exactly as described above.
// TESTING
//  1 GATE=100, WARMUP=16, osc_in toggles every 5 clk (period 10), start
//    -> result_valid after 1+16+100 cycles, result in 9..11, ovf=0.
//  2 osc_in stuck at 0, start -> result=0, result_valid=1, osc_en=0 in DONE.
//  3 CNT_W=4, osc period 4 clk, GATE=100 -> result=15, result_ovf=1.
//  4 abort in mid-COUNT (cycle 50) -> next cycle IDLE, busy=0, osc_en=0, result_valid never
//    rises; the next start gives a normal result.
//  5 result_ready held low 20 cycles in DONE -> result_valid and result stay stable;
//    start pulses ignored; ready=1 -> IDLE.
//  6 RING_OSC_CONT_EN, continuous=1, ready always 1 -> back-to-back results every
//    1+16+100 cycles (re-entering WARMUP), osc_en never drops; reset mid-COUNT -> all outputs 0.

Source files
------------

// File: rtl/ring_osc_freq_meter.sv
// ring_osc_freq_meter
//   Measurement sequencer for the divided ring-oscillator clock. On start it enables
//   the oscillator, waits WARMUP_CYCLES for it to settle, counts rising edges of osc_in
//   over exactly GATE_CYCLES clk cycles and offers the count on a valid/ready handshake.
//   All logic runs on clk; osc_in is asynchronous and passes a 2-flop synchronizer.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   start, abort        request (IDLE only) / return to IDLE from anywhere, no result
//   osc_in              divided ring-oscillator output (asynchronous)
//   continuous          only with RING_OSC_CONT_EN: re-arm after each handshake
//   result_ready        consumer accepts the result
//   osc_en, busy        oscillator enable / not IDLE
//   result, result_ovf  edge count and saturation flag, qualified by result_valid
//   result_valid        result available (high throughout DONE)
//
// Configuration macro: RING_OSC_CONT_EN (adds the continuous input)
//
// state  | meaning
// IDLE   | oscillator off, waiting for start
// WARMUP | oscillator on, settling; edges ignored
// COUNT  | oscillator on, counting edges for GATE_CYCLES cycles
// DONE   | result_valid high, waiting for result_ready
module ring_osc_freq_meter #(
  parameter int GATE_CYCLES   = 1024,
  parameter int WARMUP_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             osc_in,
`ifdef RING_OSC_CONT_EN
  input  logic             continuous,
`endif
  input  logic             result_ready,
  output logic             osc_en,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_ovf,
  output logic             result_valid
);

  localparam int TMAX = (GATE_CYCLES > WARMUP_CYCLES) ? GATE_CYCLES : WARMUP_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] GATE_LD = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] WARM_LD = TW'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, COUNT, DONE} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic             ovf_q, ovf_d, ovf_nx;
  logic [CNT_W-1:0] res_q, res_d;
  logic             res_ovf_q, res_ovf_d;
  logic             s1_q, s2_q, s3_q;
  logic             osc_edge;
  logic             rearm;

  assign osc_edge = s2_q & ~s3_q;

`ifdef RING_OSC_CONT_EN
  assign rearm = continuous;
`else
  assign rearm = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_ovf_q <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      res_ovf_q <= res_ovf_d;
      s1_q      <= osc_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
    end
  end

  // Saturating increment: an edge arriving at full scale holds the count and flags ovf.
  always_comb begin
    cnt_nx = cnt_q;
    ovf_nx = ovf_q;
    if (osc_edge) begin
      if (cnt_q == {CNT_W{1'b1}}) ovf_nx = 1'b1;
      else                        cnt_nx = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    res_ovf_d = res_ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WARMUP;
          tmr_d   = WARM_LD;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      WARMUP: begin
        if (tmr_q == '0) begin
          state_d = COUNT;
          tmr_d   = GATE_LD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      COUNT: begin
        cnt_d = cnt_nx;
        ovf_d = ovf_nx;
        if (tmr_q == '0) begin
          // last window cycle: its edge is included in the latched result
          state_d   = DONE;
          res_d     = cnt_nx;
          res_ovf_d = ovf_nx;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      DONE: begin
        if (result_ready) begin
          if (rearm) begin
            state_d = WARMUP;
            tmr_d   = WARM_LD;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // abort wins over everything, including a result latch on the final COUNT cycle
    if (abort) begin
      state_d   = IDLE;
      res_d     = res_q;
      res_ovf_d = res_ovf_q;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign osc_en       = (state_q == WARMUP) || (state_q == COUNT) ||
                        ((state_q == DONE) && rearm);
  assign result       = res_q;
  assign result_ovf   = res_ovf_q;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
module tb_ring_osc_freq_meter;

  logic        clk = 1'b0;
  logic        reset, start, abort, osc_in, result_ready;
  logic        osc_en, busy, result_ovf, result_valid;
  logic [15:0] result;
  logic        s_osc_en, s_busy, s_ovf, s_valid;
  logic [3:0]  s_result;
`ifdef RING_OSC_CONT_EN
  logic        continuous;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int osc_half = 0;
  int ph = 0;

  always #5 clk = ~clk;

  ring_osc_freq_meter #(.GATE_CYCLES(100), .WARMUP_CYCLES(16), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .osc_in(osc_in),
`ifdef RING_OSC_CONT_EN
    .continuous(continuous),
`endif
    .result_ready(result_ready), .osc_en(osc_en), .busy(busy), .result(result),
    .result_ovf(result_ovf), .result_valid(result_valid)
  );

  ring_osc_freq_meter #(.GATE_CYCLES(100), .WARMUP_CYCLES(16), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .osc_in(osc_in),
`ifdef RING_OSC_CONT_EN
    .continuous(continuous),
`endif
    .result_ready(result_ready), .osc_en(s_osc_en), .busy(s_busy), .result(s_result),
    .result_ovf(s_ovf), .result_valid(s_valid)
  );

  // oscillator model: toggles every osc_half clk cycles, held low when osc_half == 0
  always @(negedge clk) begin
    if (osc_half == 0) begin
      osc_in = 1'b0;
      ph = 0;
    end else if (ph + 1 >= osc_half) begin
      osc_in = ~osc_in;
      ph = 0;
    end else begin
      ph = ph + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pulse start, then run until result_valid; n counts edges from the start-sampling edge
  task automatic measure(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!result_valid && n < 400) begin
      tick();
      n++;
    end
  endtask

  int   n;
  int   held;
  logic [15:0] r0;
  logic seen;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; osc_in = 1'b0; result_ready = 1'b0;
`ifdef RING_OSC_CONT_EN
    continuous = 1'b0;
`endif
    repeat (3) tick();
    check("rst_osc_en", osc_en, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_ovf", result_ovf, 0);
    reset = 1'b0;
    tick();

    // period 10 over a 100-cycle window -> exactly 10 edges
    osc_half = 5;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_osc_en", osc_en, 1);
    n = 1;
    while (!result_valid && n < 400) begin
      tick();
      n++;
    end
    check("t1_latency", n, 117);
    check("t1_result", result, 10);
    check("t1_ovf", result_ovf, 0);
    check("t1_osc_en_done", osc_en, 0);
    check("t1_sat_result", s_result, 10);
    check("t1_sat_ovf", s_ovf, 0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("t1_valid_clr", result_valid, 0);
    check("t1_idle", busy, 0);
    check("t1_result_hold", result, 10);

    // period 4 -> 25 edges; the 4-bit instance saturates
    osc_half = 2;
    measure(n);
    check("t3_latency", n, 117);
    check("t3_result", result, 25);
    check("t3_ovf", result_ovf, 0);
    check("t3_sat_result", s_result, 15);
    check("t3_sat_ovf", s_ovf, 1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // stuck oscillator
    osc_half = 0;
    repeat (4) tick();
    measure(n);
    check("t2_valid", result_valid, 1);
    check("t2_result", result, 0);
    check("t2_osc_en", osc_en, 0);
    check("t2_sat_result", s_result, 0);

    // start while DONE is left in the same cycle is ignored
    result_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    result_ready = 1'b0;
    check("t5_start_on_exit", busy, 0);
    tick();
    check("t5_not_queued", busy, 0);

    // abort at COUNT cycle 50
    osc_half = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16 + 50) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_osc_en", osc_en, 0);
    check("t4_valid", result_valid, 0);
    seen = 1'b0;
    repeat (150) begin
      tick();
      if (result_valid) seen = 1'b1;
    end
    check("t4_no_valid", seen, 0);
    check("t4_result_kept", result, 0);
    measure(n);
    check("t4_latency", n, 117);
    check("t4_result", result, 10);

    // consumer stalls 20 cycles; stray starts ignored
    r0 = result;
    held = 1;
    repeat (20) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      if (!result_valid || result !== r0) held = 0;
    end
    check("t5_held", held, 1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("t5_idle", busy, 0);

    // abort in DONE discards the pending result
    osc_half = 2;
    measure(n);
    check("t7_valid", result_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t7_valid_drop", result_valid, 0);
    check("t7_idle", busy, 0);

    // reset mid-COUNT clears everything including result
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16 + 30) tick();
    reset = 1'b1;
    tick();
    check("t8_busy", busy, 0);
    check("t8_osc_en", osc_en, 0);
    check("t8_result", result, 0);
    check("t8_valid", result_valid, 0);
    reset = 1'b0;
    tick();

`ifdef RING_OSC_CONT_EN
    // continuous mode: back-to-back results every 117 cycles, enable never drops
    osc_half = 5;
    continuous = 1'b1;
    result_ready = 1'b1;
    measure(n);
    check("t6_first", n, 117);
    held = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n = 1;
      if (!osc_en) held = 0;
      while (!result_valid && n < 400) begin
        tick();
        n++;
        if (!osc_en) held = 0;
      end
      check("t6_interval", n, 117);
      check("t6_result", result, 10);
    end
    check("t6_osc_en_steady", held, 1);
    repeat (16 + 40) tick();
    reset = 1'b1;
    tick();
    check("t6_rst_busy", busy, 0);
    check("t6_rst_osc_en", osc_en, 0);
    check("t6_rst_result", result, 0);
    check("t6_rst_valid", result_valid, 0);
    check("t6_rst_ovf", result_ovf, 0);
    reset = 1'b0;
    continuous = 1'b0;
    result_ready = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
